// File: rtl/hp_rd_arb_pkg.sv
// Shared constants and types for the HP0 read arbiter: fixed AR field values,
// requester-index width carried in ARID, and the arbiter state encoding.
package hp_rd_arb_pkg;

  localparam logic [1:0] ARB_BURST_INCR = 2'b01;
  localparam logic [1:0] ARB_SIZE_64    = 2'b11;
  localparam logic [3:0] ARB_CACHE      = 4'b0011;
  localparam int         ARB_IDW        = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  // ARID carries the requester index in its low bits; upper bits are zero.
  function automatic logic [5:0] arb_arid(input logic [ARB_IDW-1:0] idx);
    return {3'b000, idx};
  endfunction

endpackage

// File: rtl/hp_rd_arb_chk.sv
// Protocol checker for the HP0 read arbiter: an R burst must never complete
// for a requester whose outstanding count is already zero.
module hp_rd_arb_chk #(
  parameter int NREQ = 2
) (
  input logic            clk,
  input logic            resetn,
  input logic [NREQ-1:0] i_dec,
  input logic [NREQ-1:0] i_cnt_zero
);

  always @(posedge clk) begin
    if (resetn) begin
      a_no_dec_at_zero: assert ((i_dec & i_cnt_zero) == '0);
    end
  end

endmodule

// File: rtl/hp_rr_pick.sv
// Combinational grant picker: first eligible index after the pointer, with wrap.
// Build with ARB_PRIO_EN defined for a fixed lowest-index-wins priority encoder.
module hp_rr_pick
  import hp_rd_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]    i_elig,
  input  logic [ARB_IDW-1:0] i_ptr,
  output logic [ARB_IDW-1:0] o_idx,
  output logic               o_vld
);

`ifdef ARB_PRIO_EN
  // Descending scan so the lowest eligible index is written last and wins.
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      o_idx = i_elig[i] ? ARB_IDW'(i) : o_idx;
      o_vld = o_vld | i_elig[i];
    end
  end
`else
  logic w_hit;

  // Distance k from the pointer scanned far-to-near so the nearest hit wins.
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    w_hit = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        w_hit = i_elig[i] && (((int'(i_ptr) + k) % NREQ) == i);
        o_idx = w_hit ? ARB_IDW'(i) : o_idx;
        o_vld = o_vld | w_hit;
      end
    end
  end
`endif

endmodule

// File: rtl/hp_rd_arb.sv
// Shares the Zynq S_AXI_HP0 read port among NREQ masters: arbitrated AR issue
// tagged with the requester index, RID-based R routing and per-requester
// outstanding-burst limits. Define ARB_PRIO_EN for fixed priority arbitration.
module hp_rd_arb
  import hp_rd_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int MAXOUT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              halt,
  output logic              idle,
  output logic              rid_err,
  input  logic [NREQ-1:0]   req_arvalid,
  output logic [NREQ-1:0]   req_arready,
  input  logic [32*NREQ-1:0] req_araddr,
  input  logic [4*NREQ-1:0] req_arlen,
  output logic [NREQ-1:0]   req_rvalid,
  input  logic [NREQ-1:0]   req_rready,
  output logic [63:0]       req_rdata,
  output logic              req_rlast,
  output logic [1:0]        req_rresp,
  output logic              sgp0_arvalid,
  input  logic              sgp0_arready,
  output logic [31:0]       sgp0_araddr,
  output logic [1:0]        sgp0_arburst,
  output logic [3:0]        sgp0_arcache,
  output logic [5:0]        sgp0_arid,
  output logic [3:0]        sgp0_arlen,
  output logic [1:0]        sgp0_arlock,
  output logic [2:0]        sgp0_arprot,
  output logic [3:0]        sgp0_arqos,
  output logic [1:0]        sgp0_arsize,
  input  logic              sgp0_rvalid,
  output logic              sgp0_rready,
  input  logic              sgp0_rlast,
  input  logic [63:0]       sgp0_rdata,
  input  logic [1:0]        sgp0_rresp,
  input  logic [5:0]        sgp0_rid
);

  localparam logic [2:0] CNT_MAX = 3'(MAXOUT);

  arb_state_t               r_state;
  arb_state_t               w_state_nxt;
  logic [ARB_IDW-1:0]       r_idx;
  logic [31:0]              r_addr;
  logic [3:0]               r_len;
  logic [NREQ-1:0][2:0]     r_cnt;
  logic                     r_rid_err;
  logic [ARB_IDW-1:0]       w_ptr;
  logic [ARB_IDW-1:0]       w_gnt_idx;
  logic                     w_gnt_vld;
  logic [NREQ-1:0]          w_elig;
  logic [NREQ-1:0]          w_inc;
  logic [NREQ-1:0]          w_dec;
  logic [NREQ-1:0]          w_cnt_zero;
  logic [31:0]              w_addr_sel;
  logic [3:0]               w_len_sel;
  logic                     w_ar_hs;
  logic                     w_rid_ok;
  logic [ARB_IDW-1:0]       w_rsel;
  logic                     w_rhit;

  assign w_ar_hs  = (r_state == ISSUE) && sgp0_arready;
  assign w_rid_ok = (sgp0_rid < 6'(NREQ));
  assign w_rsel   = sgp0_rid[ARB_IDW-1:0];

  always_comb begin
    w_elig     = '0;
    w_inc      = '0;
    w_dec      = '0;
    w_cnt_zero = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_cnt_zero[i] = (r_cnt[i] == 3'd0);
      w_elig[i]     = req_arvalid[i] && (r_cnt[i] < CNT_MAX) && !halt;
      w_inc[i]      = w_ar_hs && (r_idx == ARB_IDW'(i));
      w_dec[i]      = req_rvalid[i] && req_rready[i] && sgp0_rlast;
    end
  end

`ifdef ARB_PRIO_EN
  assign w_ptr = '0;
`else
  logic [ARB_IDW-1:0] r_ptr;

  // The last granted index becomes the starting point of the next search.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= ARB_IDW'(NREQ - 1);
    end else if (w_ar_hs) begin
      r_ptr <= r_idx;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign w_ptr = r_ptr;
`endif

  hp_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_elig (w_elig),
    .i_ptr  (w_ptr),
    .o_idx  (w_gnt_idx),
    .o_vld  (w_gnt_vld)
  );

  always_comb begin
    w_addr_sel = '0;
    w_len_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_addr_sel = (w_gnt_idx == ARB_IDW'(i)) ? req_araddr[32*i +: 32] : w_addr_sel;
      w_len_sel  = (w_gnt_idx == ARB_IDW'(i)) ? req_arlen[4*i +: 4] : w_len_sel;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    sgp0_arvalid = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = w_gnt_vld ? ISSUE : IDLE;
      end
      ISSUE: begin
        sgp0_arvalid = 1'b1;
        w_state_nxt  = sgp0_arready ? IDLE : ISSUE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Grant fields are frozen at pick time and presented unchanged through ISSUE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx  <= '0;
      r_addr <= '0;
      r_len  <= '0;
    end else if ((r_state == IDLE) && w_gnt_vld) begin
      r_idx  <= w_gnt_idx;
      r_addr <= w_addr_sel;
      r_len  <= w_len_sel;
    end else begin
      r_idx  <= r_idx;
      r_addr <= r_addr;
      r_len  <= r_len;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        case ({w_inc[i], w_dec[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + 3'd1;
          2'b01:   r_cnt[i] <= w_cnt_zero[i] ? 3'd0 : r_cnt[i] - 3'd1;
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rid_err <= 1'b0;
    end else if (sgp0_rvalid && !w_rid_ok) begin
      r_rid_err <= 1'b1;
    end else begin
      r_rid_err <= r_rid_err;
    end
  end

  // Unknown RIDs are drained (rready forced high) so the slave never stalls.
  always_comb begin
    req_rvalid  = '0;
    sgp0_rready = 1'b1;
    w_rhit      = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_rhit        = w_rid_ok && (w_rsel == ARB_IDW'(i));
      req_rvalid[i] = w_rhit && sgp0_rvalid;
      sgp0_rready   = w_rhit ? req_rready[i] : sgp0_rready;
    end
  end

  always_comb begin
    req_arready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_arready[i] = w_ar_hs && (r_idx == ARB_IDW'(i));
    end
  end

  assign idle         = (r_state == IDLE) && (&w_cnt_zero);
  assign rid_err      = r_rid_err;
  assign req_rdata    = sgp0_rdata;
  assign req_rlast    = sgp0_rlast;
  assign req_rresp    = sgp0_rresp;
  assign sgp0_araddr  = r_addr;
  assign sgp0_arid    = arb_arid(r_idx);
  assign sgp0_arlen   = r_len;
  assign sgp0_arburst = ARB_BURST_INCR;
  assign sgp0_arsize  = ARB_SIZE_64;
  assign sgp0_arcache = ARB_CACHE;
  assign sgp0_arlock  = 2'b00;
  assign sgp0_arprot  = 3'b000;
  assign sgp0_arqos   = 4'b0000;

  hp_rd_arb_chk #(.NREQ(NREQ)) u_chk (
    .clk        (clk),
    .resetn     (resetn),
    .i_dec      (w_dec),
    .i_cnt_zero (w_cnt_zero)
  );

endmodule

// File: doc/hp_rd_arb.md
Name: hp_rd_arb

Overview:
- Shares the single Zynq S_AXI_HP0 read port (64-bit AXI3, read-only) among NREQ read masters, e.g. ROM fetch and a second DMA reader.
- Round-robin grants on the AR channel and tags ARID with the requester index.
- Routes R beats back to the requester by RID and caps outstanding bursts per requester.
- Sits between the requesters and the PS7 SAXIHP0 pins, in the clk domain.

Parameters:
NREQ, 2, number of requesters (1..8); index = ARID[2:0].
MAXOUT, 4, max outstanding bursts per requester (1..7).

Ports:
clk  in  1  fabric clock (FCLK0), also SAXIHP0ACLK
resetn  in  1  asynchronous active-low reset
halt  in  1  stop issuing new bursts; in-flight bursts complete
idle  out  1  no AR pending and all outstanding counters zero
rid_err  out  1  sticky: R beat seen with RID >= NREQ
req_arvalid  in  NREQ  per-requester burst request
req_arready  out  NREQ  per-requester AR accept
req_araddr  in  32*NREQ  packed byte addresses, 8-byte aligned
req_arlen  in  4*NREQ  packed AXI3 burst length minus 1
req_rvalid  out  NREQ  beat valid for requester i
req_rready  in  NREQ  requester i accepts beat
req_rdata  out  64  broadcast read data
req_rlast  out  1  broadcast last beat
req_rresp  out  2  broadcast response
sgp0_arvalid/arready/araddr/arburst/arcache/arid/arlen/arlock/arprot/arqos/arsize  out/in/out...  1/1/32/2/4/6/4/2/3/4/2  HP0 AR channel
sgp0_rvalid  in  1;  sgp0_rready  out  1;  sgp0_rlast  in  1;  sgp0_rdata  in  64;  sgp0_rresp  in  2;  sgp0_rid  in  6  HP0 R channel

Behaviour:
- Reset: state IDLE; sgp0_arvalid=0, req_arready=0; outstanding counters=0; rr pointer = NREQ-1; rid_err=0; idle=1.
- Constant AR fields: arburst=01 (INCR), arsize=11 (8 B), arcache=0011, arlock=0, arprot=0, arqos=0.
- FSM IDLE:
  - Eligible set = req_arvalid[i] && cnt[i] < MAXOUT && !halt.
  - If the set is non-empty, pick the first eligible index after the rr pointer, with wrap.
  - Register the grant index, araddr and arlen. arid = {3'b0, idx}.
  - Go to ISSUE. First sgp0_arvalid is 1 cycle after req_arvalid is seen.
- FSM ISSUE: sgp0_arvalid=1 with the registered fields.
  - On sgp0_arready: req_arready[idx]=1 for that cycle only (combinational from sgp0_arready), cnt[idx]++, rr pointer=idx, go to IDLE.
  - Requesters hold arvalid and addr until arready (AXI rule). halt does not abort ISSUE.
  - Back-to-back grant rate: one burst per 2 cycles minimum.
- R routing, combinational:
  - r = sgp0_rid[2:0] when sgp0_rid < NREQ.
  - req_rvalid[r] = sgp0_rvalid; sgp0_rready = req_rready[r].
  - Unknown RID: sgp0_rready=1 (drain), no req_rvalid, rid_err set on each such beat.
- Counter decrement: on a handshake with sgp0_rlast, cnt[r]--. Same-cycle inc and dec on the same index leaves it unchanged.
- Counter saturation: never exceeds MAXOUT (gated by eligibility). Decrement at 0 is illegal and held at 0 (assertion).
- idle = (state==IDLE) && all cnt==0 (registered view of counters).
- Mid-operation reset: everything returns to reset values immediately. Software must not assert resetn while HP0 has bursts in flight; halt then wait for idle.

Optional Feature:
ARB_PRIO_EN
- Defined: fixed priority, lowest index wins; rr pointer is unused and removed.
- Undefined: round-robin as above.
- Outstanding limits apply in both modes.

Decomposition:
- Shared package/header (dport.vh style include): HP0 constant field values (ARB_BURST_INCR, ARB_SIZE_64, ARB_CACHE), ARB_IDW=3, state encodings IDLE/ISSUE.
- One natural sub-module: hp_rr_pick.
  - Inputs: eligible vector, pointer.
  - Outputs: grant index and valid.
  - Combinational; swappable for the priority encoder under ARB_PRIO_EN.

Test Plan:
- Single req0 burst, addr 0x1000_0000, arlen 7 → sgp0_arvalid 1 cycle later with araddr 0x1000_0000, arid 0, arlen 7. 8 beats go to req_rvalid[0] only; cnt0 returns to 0; idle=1.
- req0 and req1 both continuously valid, slave always ready → grants alternate 0,1,0,1. With ARB_PRIO_EN: all grants to 0 until cnt0 = MAXOUT(4), then req1 is granted.
- req0 issues 4 bursts with no R returned → 5th request is not granted until one rlast for RID 0 arrives; that grant follows 1 cycle later.
- Interleaved R beats RID 1,0,1 with req_rready[1]=0 for 3 cycles → sgp0_rready low for those cycles; no beat is lost or misrouted.
- Beat with RID 5 while NREQ=2 → drained, rid_err=1 and stays 1 until reset.
- halt asserted during ISSUE → that burst completes. No new ARs while halt=1; idle rises after the last rlast.
